// File: rtl/telemetry_pkg.sv
// Shared types and ASCII helpers for the hex telemetry framer.
package telemetry_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;
    typedef enum logic [1:0] {PH_DIGIT, PH_SEP, PH_CR, PH_LF} phase_t;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/hex_telemetry_framer_if.sv
// Byte-wide transmitter handshake: framer drives data/start, transmitter reports busy.
interface hex_telemetry_framer_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);

endinterface

// File: rtl/hex_byte_sequencer.sv
// Walks channel/digit/phase pointers over a frozen snapshot and presents the next ASCII byte.
module hex_byte_sequencer
    import telemetry_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int CH_WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic                       i_advance,
    input  logic [NUM_CH*CH_WIDTH-1:0] i_snapshot,
    output logic [7:0]                 o_byte,
    output logic                       o_last
);

    localparam int DIGITS = (CH_WIDTH + 3) / 4;
    localparam int PAD_W  = DIGITS * 4;
    localparam int CI_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DI_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CI_W-1:0] LAST_CI = CI_W'(NUM_CH - 1);
    localparam logic [DI_W-1:0] TOP_DI  = DI_W'(DIGITS - 1);

    logic [CI_W-1:0]     r_ci;
    logic [DI_W-1:0]     r_di;
    phase_t              r_phase;
    logic [CH_WIDTH-1:0] w_chan;
    logic [PAD_W-1:0]    w_padded;
    logic [3:0]          w_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ci    <= '0;
            r_di    <= TOP_DI;
            r_phase <= PH_DIGIT;
        end else if (i_load) begin
            r_ci    <= '0;
            r_di    <= TOP_DI;
            r_phase <= PH_DIGIT;
        end else if (i_advance) begin
            case (r_phase)
                PH_DIGIT: begin
                    if (r_di == '0)
                        r_phase <= (r_ci == LAST_CI) ? PH_CR : PH_SEP;
                    else
                        r_di <= r_di - 1'b1;
                end
                PH_SEP: begin
                    r_ci    <= r_ci + 1'b1;
                    r_di    <= TOP_DI;
                    r_phase <= PH_DIGIT;
                end
                default: r_phase <= PH_LF;
            endcase
        end
    end

    // Zero-extending the channel pads a partial top nibble with zeros.
    assign w_chan   = i_snapshot[r_ci*CH_WIDTH +: CH_WIDTH];
    assign w_padded = PAD_W'(w_chan);
    assign w_nib    = w_padded[r_di*4 +: 4];

    always_comb begin
        o_byte = nibble_to_hex(w_nib);
        case (r_phase)
            PH_SEP:  o_byte = ASCII_SP;
            PH_CR:   o_byte = ASCII_CR;
            PH_LF:   o_byte = ASCII_LF;
            default: o_byte = nibble_to_hex(w_nib);
        endcase
    end

    assign o_last = (r_phase == PH_LF);

endmodule

// File: rtl/hex_telemetry_framer.sv
// Triggers, snapshots and ships one upper-case hex ASCII line per frame over a start/busy transmitter.
module hex_telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int                NUM_CH    = 5,
    parameter int                CH_WIDTH  = 13,
    parameter logic [NUM_CH-1:0] CHG_MASK  = '1,
    parameter int                HEARTBEAT = 0
) (
    input  logic                       CLK_10MHZ,
    input  logic                       nRESET,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       send_tick,
    input  logic                       force_send,
    hex_telemetry_framer_if.master     tx,
    output logic                       frame_active,
    output logic                       frame_done,
    output logic [NUM_CH-1:0]          changed
);

    localparam int HB_W = (HEARTBEAT > 0) ? $clog2(HEARTBEAT + 1) : 1;
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HEARTBEAT);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NUM_CH*CH_WIDTH-1:0] r_last_sent;
    logic [NUM_CH*CH_WIDTH-1:0] r_snapshot;
    logic                       r_force_pend;
    logic [HB_W-1:0]            r_hb_cnt;
    logic [7:0]                 r_tx_data;
    logic                       r_tx_start;
    logic                       r_lf_sent;
    logic                       w_hb_fire;
    logic                       w_trigger;
    logic                       w_enter_load;
    logic                       w_send;
    logic [7:0]                 w_byte;
    logic                       w_last;

    always_comb begin
        changed = '0;
        for (int c = 0; c < NUM_CH; c++)
            changed[c] = ch_data[c*CH_WIDTH +: CH_WIDTH] != r_last_sent[c*CH_WIDTH +: CH_WIDTH];
    end

    // force_send is folded in directly so a same-cycle tick and force still start a frame.
    assign w_hb_fire = (HEARTBEAT != 0) && (r_hb_cnt == HB_MAX);
    assign w_trigger = (|(changed & CHG_MASK)) | r_force_pend | force_send | w_hb_fire;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_load = 1'b0;
        w_send       = 1'b0;
        case (r_state)
            IDLE: begin
                if (send_tick && w_trigger) begin
                    w_enter_load = 1'b1;
                    w_state_nxt  = LOAD;
                end
            end
            LOAD: w_state_nxt = SEND;
            SEND: begin
                if (!tx.tx_busy) begin
                    w_send      = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            // r_tx_start is high exactly in the first WAIT cycle, masking stale busy.
            WAIT: begin
                if (!r_tx_start && !tx.tx_busy)
                    w_state_nxt = r_lf_sent ? DONE : SEND;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK_10MHZ or negedge nRESET) begin
        if (!nRESET) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK_10MHZ or negedge nRESET) begin
        if (!nRESET) begin
            r_last_sent  <= '0;
            r_snapshot   <= '0;
            r_force_pend <= 1'b0;
            r_hb_cnt     <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_lf_sent    <= 1'b0;
        end else begin
            r_tx_start <= w_send;
            if (w_send) begin
                r_tx_data <= w_byte;
                r_lf_sent <= w_last;
            end else if (r_state == LOAD) begin
                r_lf_sent <= 1'b0;
            end
            if (r_state == LOAD)
                r_snapshot <= ch_data;
            // Commit the transmitted snapshot so mid-frame changes still trigger the next frame.
            if (r_state == DONE)
                r_last_sent <= r_snapshot;
            if (w_enter_load)
                r_force_pend <= 1'b0;
            else if (force_send)
                r_force_pend <= 1'b1;
            if (w_enter_load)
                r_hb_cnt <= '0;
            else if (r_state == IDLE && send_tick && r_hb_cnt != HB_MAX)
                r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    hex_byte_sequencer #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH)
    ) u_seq (
        .clk        (CLK_10MHZ),
        .rst_n      (nRESET),
        .i_load     (r_state == LOAD),
        .i_advance  (w_send),
        .i_snapshot (r_snapshot),
        .o_byte     (w_byte),
        .o_last     (w_last)
    );

    assign tx.tx_data   = r_tx_data;
    assign tx.tx_start  = r_tx_start;
    assign frame_active = (r_state != IDLE);
    assign frame_done   = (r_state == DONE);

endmodule

// File: tb/tb_hex_telemetry_framer.sv
// Scoreboard bench: two framers (plain, and heartbeat=3 with ch0-only change mask) behind 20-clock busy transmitters.
module tb_hex_telemetry_framer;

    localparam int NCH       = 2;
    localparam int CW        = 12;
    localparam int BUSY_CLKS = 20;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic [NCH*CW-1:0]  data0  = '0;
    logic [NCH*CW-1:0]  data1  = '0;
    logic               tick0  = 1'b0;
    logic               tick1  = 1'b0;
    logic               force0 = 1'b0;
    logic               force1 = 1'b0;
    logic               active0, active1, done0, done1;
    logic [NCH-1:0]     changed0, changed1;
    int                 busy_cnt0 = 0, busy_cnt1 = 0;
    int                 start_cnt0 = 0, start_cnt1 = 0;
    int                 done_cnt0 = 0, done_cnt1 = 0;
    int                 n_cmp = 0, n_bad = 0;
    logic [7:0]         q0[$];
    logic [7:0]         q1[$];

    hex_telemetry_framer_if tx0 ();
    hex_telemetry_framer_if tx1 ();

    always #5 clk = ~clk;

    hex_telemetry_framer #(
        .NUM_CH (NCH), .CH_WIDTH (CW), .CHG_MASK (2'b11), .HEARTBEAT (0)
    ) u_dut0 (
        .CLK_10MHZ (clk), .nRESET (rst_n), .ch_data (data0), .send_tick (tick0),
        .force_send (force0), .tx (tx0), .frame_active (active0), .frame_done (done0),
        .changed (changed0)
    );

    hex_telemetry_framer #(
        .NUM_CH (NCH), .CH_WIDTH (CW), .CHG_MASK (2'b01), .HEARTBEAT (3)
    ) u_dut1 (
        .CLK_10MHZ (clk), .nRESET (rst_n), .ch_data (data1), .send_tick (tick1),
        .force_send (force1), .tx (tx1), .frame_active (active1), .frame_done (done1),
        .changed (changed1)
    );

    // Transmitter model: busy for BUSY_CLKS clocks starting the cycle after start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt0 <= 0;
            busy_cnt1 <= 0;
        end else begin
            if (tx0.tx_start)       busy_cnt0 <= BUSY_CLKS;
            else if (busy_cnt0 != 0) busy_cnt0 <= busy_cnt0 - 1;
            if (tx1.tx_start)       busy_cnt1 <= BUSY_CLKS;
            else if (busy_cnt1 != 0) busy_cnt1 <= busy_cnt1 - 1;
        end
    end
    assign tx0.tx_busy = (busy_cnt0 != 0);
    assign tx1.tx_busy = (busy_cnt1 != 0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: every tx_start pops one expected byte.
    always @(negedge clk) begin
        if (tx0.tx_start) begin
            start_cnt0 <= start_cnt0 + 1;
            check("dut0 byte expected at tx_start", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) check("dut0 tx_data", tx0.tx_data, q0.pop_front());
        end
        if (tx1.tx_start) begin
            start_cnt1 <= start_cnt1 + 1;
            check("dut1 byte expected at tx_start", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) check("dut1 tx_data", tx1.tx_data, q1.pop_front());
        end
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic push_frame(input int which, input logic [NCH*CW-1:0] v);
        logic [7:0] b[$];
        for (int c = 0; c < NCH; c++) begin
            logic [CW-1:0] ch;
            ch = v[c*CW +: CW];
            for (int d = (CW + 3) / 4 - 1; d >= 0; d--) begin
                logic [3:0] n;
                n = 4'(ch >> (4 * d));
                b.push_back((n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10));
            end
            if (c < NCH - 1) b.push_back(8'h20);
        end
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) begin
            if (which == 0) q0.push_back(b[i]);
            else            q1.push_back(b[i]);
        end
    endtask

    task automatic pulse(input int which, input logic do_tick, input logic do_force);
        @(posedge clk); #1;
        if (which == 0) begin tick0 = do_tick; force0 = do_force; end
        else            begin tick1 = do_tick; force1 = do_force; end
        @(posedge clk); #1;
        tick0 = 1'b0; force0 = 1'b0; tick1 = 1'b0; force1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target, input int budget);
        int n = 0;
        while (((which == 0) ? done_cnt0 : done_cnt1) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check($sformatf("dut%0d frame_done count", which),
              64'((which == 0) ? done_cnt0 : done_cnt1), 64'(target));
    endtask

    task automatic wait_starts(input int which, input int target, input int budget);
        int n = 0;
        while (((which == 0) ? start_cnt0 : start_cnt1) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check($sformatf("dut%0d tx_start count reached", which),
              64'((which == 0) ? start_cnt0 : start_cnt1), 64'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_start", tx0.tx_start, 1'b0);
        check("reset tx_data", tx0.tx_data, 8'h00);
        check("reset frame_active", active0, 1'b0);
        check("reset frame_done", done0, 1'b0);
        check("reset last_sent", u_dut0.r_last_sent, '0);
        rst_n = 1'b1;

        // Basic frame: ch0=0x1A3 sent first, ch1=0x0FF
        @(posedge clk); #1;
        data0 = {12'h0FF, 12'h1A3};
        #1;
        check("changed after data load", changed0, 2'b11);
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 1, 600);
        check("frame1 tx_start pulses", start_cnt0, 9);
        check("frame1 last_sent", u_dut0.r_last_sent, 24'h0FF1A3);
        check("frame1 changed cleared", changed0, 2'b00);
        check("frame1 frame_active low after", active0, 1'b0);

        // Static data, no heartbeat: ticks alone do nothing
        for (int i = 0; i < 10; i++) begin
            pulse(0, 1'b1, 1'b0);
            repeat (5) @(posedge clk);
        end
        #1;
        check("static ticks no tx_start", start_cnt0, 9);
        pulse(0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("force waits for tick", start_cnt0, 9);
        check("force waits frame_active", active0, 1'b0);
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 2, 600);
        check("forced frame pulses", start_cnt0, 18);

        // Simultaneous tick+force; ch0 changes while byte 4 is in flight
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b1);
        wait_starts(0, 22, 600);
        check("frame_active mid-frame", active0, 1'b1);
        data0 = {12'h0FF, 12'h1A4};
        #1;
        check("changed mid-frame", changed0, 2'b01);
        wait_done(0, 3, 600);
        check("last_sent is snapshot", u_dut0.r_last_sent, 24'h0FF1A3);
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 4, 600);
        check("update frame pulses", start_cnt0, 36);

        // Heartbeat=3: static zero data sends on every 4th tick
        for (int t = 1; t <= 8; t++) begin
            if (t % 4 == 0) push_frame(1, data1);
            pulse(1, 1'b1, 1'b0);
            repeat (300) @(posedge clk);
            #1;
            if (t == 1) check("hb_cnt after tick1", u_dut1.r_hb_cnt, 2'd1);
            if (t == 3) check("hb_cnt after tick3", u_dut1.r_hb_cnt, 2'd3);
            if (t == 4) check("hb_cnt cleared at LOAD", u_dut1.r_hb_cnt, 2'd0);
        end
        check("heartbeat frame count", done_cnt1, 2);
        check("heartbeat tx_start count", start_cnt1, 18);

        // Mask 2'b01: ch1 change alone is ignored, ch0 change sends both channels
        data1 = {12'h055, 12'h000};
        #1;
        check("masked channel changed flag", changed1, 2'b10);
        pulse(1, 1'b1, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check("masked change no frame", done_cnt1, 2);
        data1 = {12'h055, 12'h321};
        push_frame(1, data1);
        pulse(1, 1'b1, 1'b0);
        wait_done(1, 3, 600);
        check("unmasked change pulses", start_cnt1, 27);

        // Reset during byte 5 aborts the frame
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b1);
        wait_starts(0, 41, 600);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort tx_start", tx0.tx_start, 1'b0);
        check("abort frame_active", active0, 1'b0);
        check("abort last_sent", u_dut0.r_last_sent, '0);
        q0.delete();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no tx_start after abort", start_cnt0, 41);
        check("no frame_done after abort", done_cnt0, 4);
        push_frame(0, data0);
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 5, 600);
        check("post-reset full frame", start_cnt0, 50);

        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
